wshb_arbiter2: RTL

Two-master, one-slave Wishbone arbiter that shares the 16-bit SDRAM Wishbone port between the VGA frame reader (master 0, real-time) and a frame writer such as the test-pattern generator or video input (master 1). It sits between the masters and the SDRAM controller slave. Each master sees a private classic Wishbone port, and the arbiter multiplexes exactly one of them onto the slave. A hold limit bounds how long one master can monopolise the bus, because the VGA reader keeps `cyc` asserted permanently.

---
 rtl/wshb_arbiter2.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wshb_arbiter2.sv
// Two-master / one-slave classic Wishbone arbiter with a per-grant hold limit.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to master 0.
module wshb_arbiter2 #(
  parameter int HOLD_MAX = 16,
  parameter int AW       = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [1:0]    m0_sel,
  input  logic [15:0]   m0_dat_ms,
  output logic [15:0]   m0_dat_sm,
  output logic          m0_ack,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [1:0]    m1_sel,
  input  logic [15:0]   m1_dat_ms,
  output logic [15:0]   m1_dat_sm,
  output logic          m1_ack,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [1:0]    s_sel,
  output logic [15:0]   s_dat_ms,
  input  logic [15:0]   s_dat_sm,
  input  logic          s_ack,
  output logic [1:0]    gnt
);

  localparam int            HW        = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          last_gnt, last_gnt_nxt;  // 0 = master 0, 1 = master 1
  logic          req0, req1, other_req, hold_hit;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    last_gnt_nxt = last_gnt;
    other_req    = (state == G0) ? req1 : ((state == G1) ? req0 : 1'b0);
    hold_hit     = s_ack & other_req & (hold_cnt == HOLD_LAST);

    case (state)
      IDLE: begin
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_nxt = last_gnt ? G0 : G1;
`else
          state_nxt = G0;
`endif
        end else if (req0) begin
          state_nxt = G0;
        end else if (req1) begin
          state_nxt = G1;
        end
      end
      G0: begin
        if (!m0_cyc)       state_nxt = req1 ? G1 : IDLE;
        else if (hold_hit) state_nxt = G1;
      end
      G1: begin
        if (!m1_cyc)       state_nxt = req0 ? G0 : IDLE;
        else if (hold_hit) state_nxt = G0;
      end
      default: state_nxt = IDLE;
    endcase

    // Acks only count against the hold limit while the other master is waiting.
    if (state_nxt != state || state == IDLE) hold_cnt_nxt = '0;
    else if (s_ack && other_req && hold_cnt != HOLD_LAST) hold_cnt_nxt = hold_cnt + HW'(1);

    if (state_nxt != state) begin
      if (state_nxt == G0)      last_gnt_nxt = 1'b0;
      else if (state_nxt == G1) last_gnt_nxt = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Slave side is a pure mux on the registered grant, so it only moves with state or granted inputs.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    case (state)
      G0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_ms = m0_dat_ms;
      end
      G1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_ms = m1_dat_ms;
      end
      default: ;
    endcase
  end

  assign m0_ack    = s_ack & (state == G0);
  assign m1_ack    = s_ack & (state == G1);
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign gnt       = {state == G1, state == G0};

endmodule
